bcd_addsub_pipe: RTL and testbench
==================================

Name: bcd_addsub_pipe

Overview:
- Parametrised successor of the fixed 3-digit BCD adder top level.
- Accepts two DIGITS-wide packed BCD operands plus an add/subtract mode over a valid/ready handshake.
- Converts both operands to binary iteratively, adds or subtracts them, then converts the signed-magnitude result back to DIGITS+1 BCD digits by iterative double-dabble.
- Sits between the operand-entry logic and the display/driver logic; replaces the separate load/start_conv strobes with a single in/out handshake.

Parameters:
DIGITS, 3, BCD digits per operand (1..8); result has DIGITS+1 digits.
BIN_W, bcd_pkg::bin_width(DIGITS), binary width holding 2*(10^DIGITS-1); 11 for DIGITS=3. Derived; not overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  operands and mode present.
in_ready  out  1  block can accept; high only in IDLE.
op_a  in  4*DIGITS  packed BCD, digit 0 in [3:0].
op_b  in  4*DIGITS  packed BCD.
mode  in  1  0 = a+b, 1 = a-b.
out_valid  out  1  result valid; held until consumed.
out_ready  in  1  downstream accepts result.
result  out  4*(DIGITS+1)  packed BCD magnitude.
sign  out  1  1 = result negative (subtract only).
err  out  1  an input digit exceeded 9 (see Optional Feature).

Behaviour:
- Reset values (asynchronous, immediate):
  - state IDLE, in_ready=1, out_valid=0, result=0, sign=0, err=0.
  - All internal registers cleared.
- FSM states: IDLE, TOBIN, ALU, TOBCD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture op_a, op_b and mode; clear accumulators; go to TOBIN.
- TOBIN, DIGITS cycles, most-significant digit first:
  - acc_a = acc_a*10 + digit.
  - acc_b = acc_b*10 + digit.
  - Digit counter runs DIGITS-1 down to 0, then go to ALU.
- ALU, 1 cycle:
  - Add: mag = acc_a + acc_b, sign = 0.
  - Subtract with acc_a >= acc_b: mag = acc_a - acc_b, sign = 0.
  - Subtract otherwise: mag = acc_b - acc_a, sign = 1.
  - A zero result always has sign = 0.
  - All arithmetic is BIN_W+1 bits wide, so no overflow is possible.
- TOBCD, BIN_W cycles:
  - Shift-add-3 on a 4*(DIGITS+1) BCD register; mag is shifted in MSB first.
  - Then go to DONE.
- DONE:
  - out_valid=1; result, sign and err are stable.
  - Stay until out_ready=1, then go to IDLE with out_valid=0 on the next edge.
- Latency:
  - Handshake edge to out_valid = DIGITS + 1 + BIN_W cycles (15 for DIGITS=3), independent of data.
- Throughput:
  - One operation per latency + 2 cycles when out_ready is held high.
- Handshake rules:
  - in_ready is low in every non-IDLE state. in_valid there is ignored, not queued.
  - result, sign and err change only on the ALU→DONE path. They hold their values in IDLE until the next completion.
- Reset mid-operation:
  - Aborts immediately and returns to reset values; the partial result is discarded.
- out_ready may be high before out_valid; this has no effect until DONE.

Optional Feature:
Macro: BCD_ADDSUB_DIGIT_CHECK_EN
- Defined:
  - At capture, any nibble >9 in op_a or op_b sets an internal error flag.
  - The operation still runs its full latency, but DONE presents result=0, sign=0, err=1.
- Undefined:
  - err is tied to 0.
  - Nibbles 10..15 are weighted by their binary value in TOBIN, giving an unchecked, arithmetically consistent binary result.

Decomposition:
- Package bcd_pkg holds:
  - bin_width function (ceil log2 of 2*(10^D-1)+1).
  - mode_e enum {MODE_ADD, MODE_SUB}.
  - state_e enum for the FSM.
  - BCD_MAX_DIGIT constant = 9.
- One sub-module: bcd_dabble_conv.
  - Iterative binary-to-BCD converter with start/done, parameters IN_WIDTH and DIGITS.
  - Instantiated once for the TOBCD phase; the FSM waits on its done.
- TOBIN stays inline in the FSM.

Test Plan:
- DIGITS=3, op_a=0x999, op_b=0x999, mode=0 -> after 15 cycles result=0x1998, sign=0, err=0.
- DIGITS=3, op_a=0x123, op_b=0x456, mode=1 -> result=0x0333, sign=1. Swapped operands -> result=0x0333, sign=0. op_a=op_b=0x500, mode=1 -> result=0x0000, sign=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result held stable, in_ready=0, an in_valid pulse is ignored. Raising out_ready -> in_ready=1 the next cycle.
- DIGITS=4 build, op_a=0x9999, op_b=0x0001, mode=0 -> result=0x10000, latency 4+1+15=20 cycles.
- rst pulsed during TOBCD -> out_valid=0 and in_ready=1 immediately. A new op 0x010+0x020 then gives result=0x0030.
- With BCD_ADDSUB_DIGIT_CHECK_EN, op_a=0x1A3 -> err=1, result=0. Without the macro -> err=0, result=0x0203 for op_b=0x000 (1*100 + 10*10 + 3).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the pipelined BCD add/subtract block and its
// double-dabble converter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TOBIN = 3'd1,
    ALU   = 3'd2,
    TOBCD = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Bits needed to hold every value 0 .. 2*(10^digits-1).
  function automatic int bin_width(input int digits);
    longint maxv;
    int     w;
    maxv = 1;
    for (int i = 0; i < digits; i++) begin
      maxv = maxv * 10;
    end
    maxv = 2 * (maxv - 1) + 1;
    w = 1;
    while ((longint'(1) << w) < maxv) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_dabble_conv.sv
// Iterative binary-to-BCD converter (shift-add-3). One bit per cycle after a
// start pulse; done_o pulses for one cycle once bcd_o holds the final value.
module bcd_dabble_conv #(
  parameter int IN_WIDTH = 12,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [IN_WIDTH-1:0]   bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = $clog2(IN_WIDTH);

  logic [IN_WIDTH-1:0] sh_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;

  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The two leading bits need no add-3 correction, so the start edge loads
  // them directly; the remaining IN_WIDTH-2 bits take one cycle each.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bcd_q  <= {{(4*DIGITS-2){1'b0}}, bin_i[IN_WIDTH-1 -: 2]};
        sh_q   <= bin_i << 2;
        cnt_q  <= CNT_W'(IN_WIDTH - 2);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        bcd_q <= (adj_d << 1) | (4*DIGITS)'(sh_q[IN_WIDTH-1]);
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/bcd_addsub_pipe.sv
// Multi-cycle BCD add/subtract: BCD->binary, signed-magnitude ALU, binary->BCD.
// Optional input digit checking is enabled with `define BCD_ADDSUB_DIGIT_CHECK_EN.
module bcd_addsub_pipe
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 3,
  localparam int BIN_W  = bcd_pkg::bin_width(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS+3:0]   result,
  output logic                  sign,
  output logic                  err
);

  localparam int ACC_W = BIN_W + 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e               state_q;
  logic [4*DIGITS-1:0]  op_a_q;
  logic [4*DIGITS-1:0]  op_b_q;
  mode_e                mode_q;
  logic [DIG_W-1:0]     dig_q;
  logic [ACC_W-1:0]     acc_a_q;
  logic [ACC_W-1:0]     acc_b_q;
  logic                 sign_pend_q;
  logic                 err_pend_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [4*DIGITS+3:0]  result_q;
  logic                 sign_q;
  logic                 err_q;

  logic [3:0]           digit_a;
  logic [3:0]           digit_b;
  logic [ACC_W-1:0]     acc_a_d;
  logic [ACC_W-1:0]     acc_b_d;
  logic [ACC_W-1:0]     mag_d;
  logic                 sign_d;
  logic                 bad_digit;
  logic                 conv_start;
  logic                 conv_done;
  logic [4*DIGITS+3:0]  conv_bcd;

`ifdef BCD_ADDSUB_DIGIT_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((op_a[4*i +: 4] > BCD_MAX_DIGIT) || (op_b[4*i +: 4] > BCD_MAX_DIGIT)) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  // Horner step; out-of-range nibbles are simply weighted by their binary value.
  always_comb begin
    digit_a = op_a_q[4*dig_q +: 4];
    digit_b = op_b_q[4*dig_q +: 4];
    acc_a_d = (acc_a_q << 3) + (acc_a_q << 1) + ACC_W'(digit_a);
    acc_b_d = (acc_b_q << 3) + (acc_b_q << 1) + ACC_W'(digit_b);
  end

  always_comb begin
    mag_d  = acc_a_q + acc_b_q;
    sign_d = 1'b0;
    if (mode_q == MODE_SUB) begin
      if (acc_a_q >= acc_b_q) begin
        mag_d = acc_a_q - acc_b_q;
      end else begin
        mag_d  = acc_b_q - acc_a_q;
        sign_d = 1'b1;
      end
    end
  end

  assign conv_start = (state_q == ALU);

  bcd_dabble_conv #(
    .IN_WIDTH (ACC_W),
    .DIGITS   (DIGITS + 1)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (mag_d),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      mode_q      <= MODE_ADD;
      dig_q       <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      sign_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a_q     <= op_a;
            op_b_q     <= op_b;
            mode_q     <= mode_e'(mode);
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            dig_q      <= DIG_W'(DIGITS - 1);
            err_pend_q <= bad_digit;
            in_ready_q <= 1'b0;
            state_q    <= TOBIN;
          end
        end
        TOBIN: begin
          acc_a_q <= acc_a_d;
          acc_b_q <= acc_b_d;
          if (dig_q == '0) begin
            state_q <= ALU;
          end else begin
            dig_q <= dig_q - 1'b1;
          end
        end
        ALU: begin
          sign_pend_q <= sign_d;
          state_q     <= TOBCD;
        end
        TOBCD: begin
          if (conv_done) begin
            result_q    <= err_pend_q ? '0 : conv_bcd;
            sign_q      <= err_pend_q ? 1'b0 : sign_pend_q;
            err_q       <= err_pend_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sign      = sign_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_addsub_pipe.sv
// Directed self-checking bench for bcd_addsub_pipe: a 3-digit instance driven
// from a vector table plus hand sequences, and a 4-digit instance.
module tb_bcd_addsub_pipe;

  logic clk = 1'b0;
  logic rst;

  logic        inValid;
  logic        inReady;
  logic [11:0] opA;
  logic [11:0] opB;
  logic        modeIn;
  logic        outValid;
  logic        outReady;
  logic [15:0] result;
  logic        sign;
  logic        err;

  logic        inValid4;
  logic        inReady4;
  logic [15:0] opA4;
  logic [15:0] opB4;
  logic        modeIn4;
  logic        outValid4;
  logic        outReady4;
  logic [19:0] result4;
  logic        sign4;
  logic        err4;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        m;
    logic [15:0] expResult;
    logic        expSign;
    logic        expErr;
  } vec_t;

  vec_t vecs[12];

  bcd_addsub_pipe #(.DIGITS(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .op_a      (opA),
    .op_b      (opB),
    .mode      (modeIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .sign      (sign),
    .err       (err)
  );

  bcd_addsub_pipe #(.DIGITS(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid4),
    .in_ready  (inReady4),
    .op_a      (opA4),
    .op_b      (opB4),
    .mode      (modeIn4),
    .out_valid (outValid4),
    .out_ready (outReady4),
    .result    (result4),
    .sign      (sign4),
    .err       (err4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called #1 after a clock edge; returns cycles from handshake edge to out_valid.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b, input logic m, output int lat);
    int guard;
    guard = 0;
    while (!inReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    opA = a; opB = b; modeIn = m; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string name);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput({name, " out_valid drop"}, 32'(outValid), 32'd0);
    checkOutput({name, " in_ready back"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    int lat;
    int cyc;
    int pulses;
    int firstPulse;
    int secondPulse;
    int spurious;

    vecs[0]  = '{12'h999, 12'h999, 1'b0, 16'h1998, 1'b0, 1'b0};
    vecs[1]  = '{12'h123, 12'h456, 1'b1, 16'h0333, 1'b1, 1'b0};
    vecs[2]  = '{12'h456, 12'h123, 1'b1, 16'h0333, 1'b0, 1'b0};
    vecs[3]  = '{12'h500, 12'h500, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{12'h000, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{12'h001, 12'h000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6]  = '{12'h000, 12'h999, 1'b1, 16'h0999, 1'b1, 1'b0};
    vecs[7]  = '{12'h250, 12'h750, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{12'h987, 12'h123, 1'b1, 16'h0864, 1'b0, 1'b0};
    vecs[9]  = '{12'h078, 12'h089, 1'b0, 16'h0167, 1'b0, 1'b0};
`ifdef BCD_ADDSUB_DIGIT_CHECK_EN
    vecs[10] = '{12'h1A3, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b1};
`else
    vecs[10] = '{12'h1A3, 12'h000, 1'b0, 16'h0203, 1'b0, 1'b0};
`endif
    vecs[11] = '{12'h010, 12'h020, 1'b0, 16'h0030, 1'b0, 1'b0};

    rst = 1'b1;
    inValid = 1'b0; opA = '0; opB = '0; modeIn = 1'b0; outReady = 1'b0;
    inValid4 = 1'b0; opA4 = '0; opB4 = '0; modeIn4 = 1'b0; outReady4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset sign", 32'(sign), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m, lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd15);
      checkOutput($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].expResult));
      checkOutput($sformatf("vec%0d sign", i), 32'(sign), 32'(vecs[i].expSign));
      checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].expErr));
      consume($sformatf("vec%0d", i));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle hold result", 32'(result), 32'h0030);

    // Backpressure: result held, in_valid pulse while busy is dropped.
    applyStimulus(12'h321, 12'h123, 1'b0, lat);
    checkOutput("bp latency", 32'(lat), 32'd15);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        opA = 12'h111; opB = 12'h111; inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput($sformatf("bp hold result c%0d", c), 32'(result), 32'h0444);
      checkOutput($sformatf("bp out_valid c%0d", c), 32'(outValid), 32'd1);
      checkOutput($sformatf("bp in_ready c%0d", c), 32'(inReady), 32'd0);
    end
    inValid = 1'b0;
    consume("bp");
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (outValid || !inReady) spurious++;
    end
    checkOutput("bp pulse ignored", 32'(spurious), 32'd0);
    checkOutput("bp result after", 32'(result), 32'h0444);

    // Throughput with in_valid and out_ready held high.
    opA = 12'h005; opB = 12'h007; modeIn = 1'b0; inValid = 1'b1; outReady = 1'b1;
    cyc = 0; pulses = 0; firstPulse = 0; secondPulse = 0;
    while (pulses < 2 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (outValid) begin
        if (pulses == 0) firstPulse = cyc;
        else secondPulse = cyc;
        pulses++;
      end
    end
    inValid = 1'b0;
    checkOutput("tp pulses", 32'(pulses), 32'd2);
    checkOutput("tp first", 32'(firstPulse), 32'd16);
    checkOutput("tp interval", 32'(secondPulse - firstPulse), 32'd17);
    checkOutput("tp result", 32'(result), 32'h0012);
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("tp idle", 32'(inReady), 32'd1);

    // Reset during TOBCD.
    opA = 12'h999; opB = 12'h111; modeIn = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrst busy", 32'(inReady), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", 32'(outValid), 32'd0);
    checkOutput("midrst in_ready", 32'(inReady), 32'd1);
    checkOutput("midrst result", 32'(result), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(12'h010, 12'h020, 1'b0, lat);
    checkOutput("postrst latency", 32'(lat), 32'd15);
    checkOutput("postrst result", 32'(result), 32'h0030);
    consume("postrst");

    // Four-digit instance.
    opA4 = 16'h9999; opB4 = 16'h0001; modeIn4 = 1'b0; inValid4 = 1'b1;
    @(posedge clk); #1;
    inValid4 = 1'b0;
    lat = 0;
    while (!outValid4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("d4 latency", 32'(lat), 32'd20);
    checkOutput("d4 result", 32'(result4), 32'h10000);
    checkOutput("d4 sign", 32'(sign4), 32'd0);
    outReady4 = 1'b1;
    @(posedge clk); #1;
    outReady4 = 1'b0;
    checkOutput("d4 in_ready", 32'(inReady4), 32'd1);

    opA4 = 16'h0001; opB4 = 16'h9999; modeIn4 = 1'b1; inValid4 = 1'b1;
    @(posedge clk); #1;
    inValid4 = 1'b0;
    lat = 0;
    while (!outValid4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("d4 sub latency", 32'(lat), 32'd20);
    checkOutput("d4 sub result", 32'(result4), 32'h09998);
    checkOutput("d4 sub sign", 32'(sign4), 32'd1);
    outReady4 = 1'b1;
    @(posedge clk); #1;
    outReady4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
